// File: rtl/at93c46_master.sv
// Command-level master for an AT93C46 serial EEPROM in x8 organisation.
// Issues READ/WRITE/EWEN/EWDS frames on CS/SK/DI and polls DO for write completion.
module at93c46_master #(
  parameter logic [8:0]  SK_HALF_CYCLES      = 9'd200,
  parameter logic [19:0] POLL_TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic       SYSCLK_IN,
  input  logic       RESET_IN,
  input  logic       CMD_START_IN,
  input  logic [1:0] CMD_OP_IN,
  input  logic [6:0] CMD_ADDR_IN,
  input  logic [7:0] CMD_WDATA_IN,
  output logic       CMD_BUSY_OUT,
  output logic       CMD_DONE_OUT,
  output logic [7:0] CMD_RDATA_OUT,
  output logic       CMD_TIMEOUT_OUT,
  output logic       AT93C46_CS_OUT,
  output logic       AT93C46_SK_OUT,
  output logic       AT93C46_DI_OUT,
  input  logic       AT93C46_DO_IN
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_EWEN  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_END, S_CS_GAP, S_POLL, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  hc_q, hc_d;
  logic [4:0]  bit_q, bit_d;
  logic [19:0] poll_q, poll_d;
  logic        cs_q, cs_d;
  logic        sk_q, sk_d;
  logic        di_q, di_d;
  logic [1:0]  op_q, op_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic        do_meta_q, do_sync_q;

  logic        tick;
  logic [8:0]  hc_next;
  logic [4:0]  bit_nxt;
  logic [4:0]  last_bit;
  logic [17:0] frame;

  assign tick    = (hc_q == SK_HALF_CYCLES - 9'd1);
  assign hc_next = tick ? '0 : hc_q + 9'd1;
  assign bit_nxt = bit_q + 5'd1;

  // Full serial frame, MSB first: start, opcode, address, write data (zero otherwise).
  always_comb begin
    frame    = '0;
    last_bit = 5'd17;
    case (op_q)
      OP_READ:  frame = {1'b1, 2'b10, addr_q, 8'h00};
      OP_WRITE: frame = {1'b1, 2'b01, addr_q, wdata_q};
      OP_EWEN:  frame = {1'b1, 2'b00, 7'b1100000, 8'h00};
      default:  frame = {1'b1, 2'b00, 7'b0000000, 8'h00};
    endcase
    if (op_q == OP_EWEN || op_q == 2'b11) last_bit = 5'd9;
  end

  always_ff @(posedge SYSCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      do_meta_q <= 1'b0;
      do_sync_q <= 1'b0;
    end else begin
      do_meta_q <= AT93C46_DO_IN;
      do_sync_q <= do_meta_q;
    end
  end

  always_ff @(posedge SYSCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q   <= S_IDLE;
      hc_q      <= '0;
      bit_q     <= '0;
      poll_q    <= '0;
      cs_q      <= 1'b0;
      sk_q      <= 1'b0;
      di_q      <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      bit_q     <= bit_d;
      poll_q    <= poll_d;
      cs_q      <= cs_d;
      sk_q      <= sk_d;
      di_q      <= di_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hc_d      = '0;
    bit_d     = bit_q;
    poll_d    = '0;
    cs_d      = cs_q;
    sk_d      = sk_q;
    di_d      = di_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (CMD_START_IN) begin
          state_d   = S_CS_SETUP;
          op_d      = CMD_OP_IN;
          addr_d    = CMD_ADDR_IN;
          wdata_d   = CMD_WDATA_IN;
          cs_d      = 1'b1;
          sk_d      = 1'b0;
          di_d      = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_CS_SETUP: begin
        hc_d = hc_next;
        if (tick) begin
          state_d = S_SHIFT;
          sk_d    = 1'b0;
          di_d    = frame[17];
        end
      end
      // sk_q doubles as the phase flag: low phase ends with a rise, high phase with a fall.
      S_SHIFT: begin
        hc_d = hc_next;
        if (tick) begin
          if (!sk_q) begin
            sk_d = 1'b1;
            if (op_q == OP_READ && bit_q >= 5'd10) rx_d = {rx_q[6:0], do_sync_q};
          end else if (bit_q == last_bit) begin
            state_d = S_CS_END;
            sk_d    = 1'b0;
            di_d    = 1'b0;
          end else begin
            bit_d = bit_nxt;
            sk_d  = 1'b0;
            di_d  = frame[5'd17 - bit_nxt];
          end
        end
      end
      S_CS_END: begin
        hc_d = hc_next;
        if (tick) begin
          cs_d  = 1'b0;
          bit_d = '0;
          if (op_q == OP_WRITE) begin
            state_d = S_CS_GAP;
          end else begin
            state_d = S_DONE;
            if (op_q == OP_READ) rdata_d = rx_q;
          end
        end
      end
      S_CS_GAP: begin
        hc_d = hc_next;
        if (tick) begin
          state_d = S_POLL;
          cs_d    = 1'b1;
        end
      end
      S_POLL: begin
        if (do_sync_q) begin
          state_d = S_DONE;
          cs_d    = 1'b0;
        end else if (poll_q == POLL_TIMEOUT_CYCLES - 20'd1) begin
          state_d   = S_DONE;
          cs_d      = 1'b0;
          timeout_d = 1'b1;
        end else begin
          poll_d = poll_q + 20'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b0;
        sk_d    = 1'b0;
        di_d    = 1'b0;
      end
    endcase
  end

  assign CMD_BUSY_OUT    = (state_q != S_IDLE);
  assign CMD_DONE_OUT    = (state_q == S_DONE);
  assign CMD_RDATA_OUT   = rdata_q;
  assign CMD_TIMEOUT_OUT = timeout_q;
  assign AT93C46_CS_OUT  = cs_q;
  assign AT93C46_SK_OUT  = sk_q;
  assign AT93C46_DI_OUT  = di_q;

endmodule

// File: tb/tb_at93c46_master.sv
// Directed bench for at93c46_master with a small EEPROM-side model on DO.
module tb_at93c46_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = '0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, tmo, cs, sk, di;
  logic [7:0] rdata;
  logic       do_in;

  logic       rd_mode = 1'b0;
  logic [7:0] rd_byte = '0;
  logic       dev_do_rd = 1'b0;
  logic       poll_do = 1'b0;
  assign do_in = rd_mode ? dev_do_rd : poll_do;

  always #5 clk = ~clk;

  at93c46_master #(
    .SK_HALF_CYCLES(9'd2),
    .POLL_TIMEOUT_CYCLES(20'd1000)
  ) dut (
    .SYSCLK_IN(clk),
    .RESET_IN(rst),
    .CMD_START_IN(start),
    .CMD_OP_IN(op),
    .CMD_ADDR_IN(addr),
    .CMD_WDATA_IN(wdata),
    .CMD_BUSY_OUT(busy),
    .CMD_DONE_OUT(done),
    .CMD_RDATA_OUT(rdata),
    .CMD_TIMEOUT_OUT(tmo),
    .AT93C46_CS_OUT(cs),
    .AT93C46_SK_OUT(sk),
    .AT93C46_DI_OUT(di),
    .AT93C46_DO_IN(do_in)
  );

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Serial-side monitor and READ data source; restarts its log at each command accept.
  int          pulses = 0;
  logic [17:0] di_sh = '0;
  int          cs_bad = 0, per_bad = 0, di_bad = 0;
  int          cyc = 0, last_rise = 0;
  bit          have_rise = 1'b0;
  logic        busy_p = 1'b0, sk_p = 1'b0, di_p = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && !busy_p) begin
        pulses    = 0;
        di_sh     = '0;
        have_rise = 1'b0;
      end
      if (sk && !sk_p) begin
        pulses++;
        di_sh = {di_sh[16:0], di};
        if (!cs) cs_bad++;
        if (have_rise && (cyc - last_rise) != 4) per_bad++;
        have_rise = 1'b1;
        last_rise = cyc;
        if (pulses >= 10 && pulses <= 17) dev_do_rd = rd_byte[3'(17 - pulses)];
        else dev_do_rd = 1'b0;
      end
      if (sk && (di !== di_p)) di_bad++;
      busy_p = busy;
      sk_p   = sk;
      di_p   = di;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  task automatic start_cmd(input logic [1:0] o, input logic [6:0] a, input logic [7:0] w);
    op = o; addr = a; wdata = w; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("timeout_cleared", 32'(tmo), 0);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  task automatic wait_cs(input logic lvl, input int limit, output int n);
    n = 0;
    while (cs !== lvl && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("cs_level", 32'(cs), 32'(lvl));
  endtask

  initial begin
    int n, g, k, dn;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 32'(cs), 0);
    check("rst_sk", 32'(sk), 0);
    check("rst_di", 32'(di), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tmo", 32'(tmo), 0);
    check("rst_rdata", 32'(rdata), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // EWEN, then a start held on the DONE cycle must be ignored
    start_cmd(2'b10, 7'h55, 8'hFF);
    wait_done(200, n);
    check("ewen_di", 32'(di_sh[9:0]), 32'(10'b1001100000));
    check("ewen_pulses", 32'(pulses), 10);
    check("ewen_tmo", 32'(tmo), 0);
    check("ewen_done_cs", 32'(cs), 0);
    start = 1'b1; op = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_start_ignored", 32'(busy), 0);
    check("idle_cs", 32'(cs), 0);
    check("done_one_cycle", 32'(done), 0);

    // READ 0x05 returning 0xA5
    rd_mode = 1'b1; rd_byte = 8'hA5;
    start_cmd(2'b00, 7'h05, 8'h00);
    wait_done(200, n);
    check("read_rdata", 32'(rdata), 32'h A5);
    check("read_di", 32'(di_sh), 32'({10'b1100000101, 8'h00}));
    check("read_pulses", 32'(pulses), 18);
    rd_mode = 1'b0;
    @(posedge clk);
    #1;
    check("read_busy_after", 32'(busy), 0);

    // WRITE 0x7F <- 0x3C, device ready after 500 poll cycles
    poll_do = 1'b0;
    start_cmd(2'b01, 7'h7F, 8'h3C);
    wait_cs(1'b0, 200, n);
    wait_cs(1'b1, 20, g);
    check("write_gap_len", 32'(g), 2);
    check("write_pulses", 32'(pulses), 18);
    check("write_di", 32'(di_sh), 32'(18'b1011111111_00111100));
    repeat (500) begin
      @(posedge clk);
      #1;
    end
    poll_do = 1'b1;
    n = 500;
    while (!done && n < 1200) begin
      @(posedge clk);
      #1;
      n++;
    end
    poll_do = 1'b0;
    check("write_done", 32'(done), 1);
    check("write_poll_latency", 32'(n), 503);
    check("write_tmo", 32'(tmo), 0);
    check("write_rdata_hold", 32'(rdata), 32'h A5);

    // WRITE with DO stuck low: poll timeout
    @(posedge clk);
    #1;
    start_cmd(2'b01, 7'h12, 8'h00);
    wait_cs(1'b0, 200, n);
    wait_cs(1'b1, 20, g);
    n = 0;
    while (!done && n < 1500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tmo_latency", 32'(n), 1000);
    check("tmo_flag", 32'(tmo), 1);
    check("tmo_done_cs", 32'(cs), 0);
    repeat (5) @(posedge clk);
    #1;
    check("tmo_hold", 32'(tmo), 1);
    check("tmo_cs_after", 32'(cs), 0);
    check("tmo_busy_after", 32'(busy), 0);

    // READ 0x11: second start mid-frame, reset at SK pulse 7
    rd_mode = 1'b1; rd_byte = 8'hFF;
    start_cmd(2'b00, 7'h11, 8'h00);
    k = 0;
    while (pulses < 3 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b1; op = 2'b10; addr = 7'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (pulses < 7 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("abort_pulse7", 32'(pulses), 7);
    check("abort_hdr", 32'(di_sh[6:0]), 32'(7'b1100010));
    rst = 1'b1;
    #1;
    check("abort_cs", 32'(cs), 0);
    check("abort_sk", 32'(sk), 0);
    check("abort_di", 32'(di), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_rdata", 32'(rdata), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 0);
    check("abort_idle", 32'(busy), 0);

    // Fresh READ 0x2A returning 0x96
    rd_byte = 8'h96;
    start_cmd(2'b00, 7'h2A, 8'h00);
    wait_done(200, n);
    check("read2_rdata", 32'(rdata), 32'h96);
    check("read2_di", 32'(di_sh), 32'({10'b1100101010, 8'h00}));
    check("read2_pulses", 32'(pulses), 18);
    rd_mode = 1'b0;

    check("cs_high_at_rises", 32'(cs_bad), 0);
    check("sk_period_4", 32'(per_bad), 0);
    check("di_stable_sk_high", 32'(di_bad), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
